// File: rtl/cdb_pkg.sv
// rtl/cdb_pkg.sv - shared CDB types, bus constants and combo arbiter addresses
package cdb_pkg;

    typedef logic [7:0] cdb_addr_t;

    localparam cdb_addr_t CDB_IDLE_ADDRESS = 8'hFF;
    localparam int        CDB_BUS_COUNT    = 2;

    // Address each execution combo's local arbiter compares against the selects
    localparam cdb_addr_t CDB_ADDR_ALU0   = 8'd0;
    localparam cdb_addr_t CDB_ADDR_ALU1   = 8'd1;
    localparam cdb_addr_t CDB_ADDR_ALU2   = 8'd2;
    localparam cdb_addr_t CDB_ADDR_ALU3   = 8'd3;
    localparam cdb_addr_t CDB_ADDR_BRANCH = 8'd4;
    localparam cdb_addr_t CDB_ADDR_LOAD   = 8'd5;
    localparam cdb_addr_t CDB_ADDR_STORE  = 8'd6;
    localparam cdb_addr_t CDB_ADDR_MULDIV = 8'd7;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - round-robin pick of the first two eligible requesters
module rr_pick2 #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     elig,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] first_idx,
    output logic             first_valid,
    output logic [IDX_W-1:0] second_idx,
    output logic             second_valid
);

    // Two copies back to back let a window starting at ptr run past N-1 without wrap logic
    logic [2*N-1:0] w_dbl;
    assign w_dbl = {elig, elig};

    // Scan the N-wide window [ptr, ptr+N) of the doubled vector, keeping the first two hits
    always_comb begin
        first_idx    = '0;
        first_valid  = 1'b0;
        second_idx   = '0;
        second_valid = 1'b0;
        for (int j = 0; j < 2 * N; j++) begin
            if ((j >= int'(ptr)) && (j < int'(ptr) + N) && w_dbl[j]) begin
                if (!first_valid) begin
                    first_valid = 1'b1;
                    first_idx   = IDX_W'(j % N);
                end else if (!second_valid) begin
                    second_valid = 1'b1;
                    second_idx   = IDX_W'(j % N);
                end
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - two-bus CDB scheduler: masking, bus mapping, flush and pointer
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int        N            = 8,
    parameter cdb_addr_t IDLE_ADDRESS = CDB_IDLE_ADDRESS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N-1:0]             get_bus,
    input  logic [CDB_BUS_COUNT-1:0] bus_enable,
    input  logic                     flush,
    output cdb_addr_t                select_0,
    output cdb_addr_t                select_1,
    output logic [N-1:0]             grant_vec
);

    localparam int PTR_W = $clog2(N);

    logic [PTR_W-1:0] r_rr_ptr;
    cdb_addr_t        r_select_0;
    cdb_addr_t        r_select_1;
    logic [N-1:0]     r_grant_vec;

    logic [N-1:0]     w_elig;
    logic [PTR_W-1:0] w_a_idx;
    logic             w_a_valid;
    logic [PTR_W-1:0] w_b_idx;
    logic             w_b_valid;

    cdb_addr_t        w_select_0_n;
    cdb_addr_t        w_select_1_n;
    logic [N-1:0]     w_grant_vec_n;
    logic [PTR_W-1:0] w_rr_ptr_n;

    // A requester on the bus this cycle still shows get_bus for that same result
    assign w_elig = get_bus & ~r_grant_vec;

    rr_pick2 #(
        .N     (N),
        .IDX_W (PTR_W)
    ) u_pick (
        .elig         (w_elig),
        .ptr          (r_rr_ptr),
        .first_idx    (w_a_idx),
        .first_valid  (w_a_valid),
        .second_idx   (w_b_idx),
        .second_valid (w_b_valid)
    );

    function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] idx);
        if (idx == PTR_W'(N - 1)) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    // Map picks onto enabled buses; the pointer follows the last requester actually granted
    always_comb begin
        w_select_0_n  = IDLE_ADDRESS;
        w_select_1_n  = IDLE_ADDRESS;
        w_grant_vec_n = '0;
        w_rr_ptr_n    = r_rr_ptr;
        if (!flush) begin
            case (bus_enable)
                2'b11: begin
                    if (w_a_valid) begin
                        w_select_0_n           = cdb_addr_t'(w_a_idx);
                        w_grant_vec_n[w_a_idx] = 1'b1;
                        w_rr_ptr_n             = ptr_after(w_a_idx);
                    end
                    if (w_b_valid) begin
                        w_select_1_n           = cdb_addr_t'(w_b_idx);
                        w_grant_vec_n[w_b_idx] = 1'b1;
                        w_rr_ptr_n             = ptr_after(w_b_idx);
                    end
                end
                2'b01: begin
                    if (w_a_valid) begin
                        w_select_0_n           = cdb_addr_t'(w_a_idx);
                        w_grant_vec_n[w_a_idx] = 1'b1;
                        w_rr_ptr_n             = ptr_after(w_a_idx);
                    end
                end
                2'b10: begin
                    if (w_a_valid) begin
                        w_select_1_n           = cdb_addr_t'(w_a_idx);
                        w_grant_vec_n[w_a_idx] = 1'b1;
                        w_rr_ptr_n             = ptr_after(w_a_idx);
                    end
                end
                default: begin
                    w_select_0_n = IDLE_ADDRESS;
                end
            endcase
        end
    end

    // Grant registers; reset drops both buses to idle immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr    <= '0;
            r_select_0  <= IDLE_ADDRESS;
            r_select_1  <= IDLE_ADDRESS;
            r_grant_vec <= '0;
        end else begin
            r_rr_ptr    <= w_rr_ptr_n;
            r_select_0  <= w_select_0_n;
            r_select_1  <= w_select_1_n;
            r_grant_vec <= w_grant_vec_n;
        end
    end

    assign select_0  = r_select_0;
    assign select_1  = r_select_1;
    assign grant_vec = r_grant_vec;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - scoreboard bench for cdb_arbiter
module tb_cdb_arbiter;

    localparam int N = 8;

    typedef struct packed {
        logic [7:0]   sel0;
        logic [7:0]   sel1;
        logic [N-1:0] gv;
    } exp_t;

    logic         clk;
    logic         reset;
    logic [N-1:0] get_bus;
    logic [1:0]   bus_enable;
    logic         flush;
    logic [7:0]   select_0;
    logic [7:0]   select_1;
    logic [N-1:0] grant_vec;

    int total;
    int bad;

    exp_t         q[$];
    int           m_ptr;
    logic [N-1:0] m_gv;

    cdb_arbiter #(.N(N), .IDLE_ADDRESS(8'hFF)) dut (
        .clk        (clk),
        .reset      (reset),
        .get_bus    (get_bus),
        .bus_enable (bus_enable),
        .flush      (flush),
        .select_0   (select_0),
        .select_1   (select_1),
        .grant_vec  (grant_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_push();
        exp_t         e;
        logic [N-1:0] el;
        int           a, b;
        bit           av, bv;
        el = get_bus & ~m_gv;
        av = 0; bv = 0; a = 0; b = 0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (el[idx]) begin
                if (!av) begin av = 1; a = idx; end
                else if (!bv) begin bv = 1; b = idx; end
            end
        end
        e.sel0 = 8'hFF; e.sel1 = 8'hFF; e.gv = '0;
        if (!flush) begin
            if (bus_enable == 2'b11) begin
                if (av) begin e.sel0 = 8'(a); e.gv[a] = 1'b1; m_ptr = (a + 1) % N; end
                if (bv) begin e.sel1 = 8'(b); e.gv[b] = 1'b1; m_ptr = (b + 1) % N; end
            end else if (bus_enable == 2'b01) begin
                if (av) begin e.sel0 = 8'(a); e.gv[a] = 1'b1; m_ptr = (a + 1) % N; end
            end else if (bus_enable == 2'b10) begin
                if (av) begin e.sel1 = 8'(a); e.gv[a] = 1'b1; m_ptr = (a + 1) % N; end
            end
        end
        m_gv = e.gv;
        q.push_back(e);
    endtask

    task automatic step(input string nm);
        exp_t e;
        model_push();
        @(posedge clk);
        #1;
        e = q.pop_front();
        total++;
        if (select_0 !== e.sel0) begin
            bad++;
            $display("FAIL %s sb_sel0 got=%h want=%h", nm, select_0, e.sel0);
        end
        total++;
        if (select_1 !== e.sel1) begin
            bad++;
            $display("FAIL %s sb_sel1 got=%h want=%h", nm, select_1, e.sel1);
        end
        total++;
        if (grant_vec !== e.gv) begin
            bad++;
            $display("FAIL %s sb_gv got=%h want=%h", nm, grant_vec, e.gv);
        end
    endtask

    task automatic expect_out(input string nm, input logic [7:0] s0, input logic [7:0] s1,
                              input logic [N-1:0] gv);
        total++;
        if (select_0 !== s0 || select_1 !== s1 || grant_vec !== gv) begin
            bad++;
            $display("FAIL %s got=(%h,%h,%h) want=(%h,%h,%h)", nm, select_0, select_1,
                     grant_vec, s0, s1, gv);
        end
    endtask

    task automatic expect_ptr(input string nm, input int p);
        total++;
        if (dut.r_rr_ptr !== 3'(p)) begin
            bad++;
            $display("FAIL %s rr_ptr got=%0d want=%0d", nm, dut.r_rr_ptr, p);
        end
    endtask

    task automatic apply_reset();
        get_bus = '0; bus_enable = 2'b11; flush = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_ptr = 0; m_gv = '0; q.delete();
    endtask

    task automatic test_reset();
        apply_reset();
        expect_out("reset_state", 8'hFF, 8'hFF, 8'h00);
        expect_ptr("reset_ptr", 0);
    endtask

    task automatic test_single();
        apply_reset();
        get_bus = 8'b0000_0001; bus_enable = 2'b11;
        step("single_grant");
        expect_out("single_grant", 8'h00, 8'hFF, 8'h01);
        step("single_masked");
        expect_out("single_masked", 8'hFF, 8'hFF, 8'h00);
        step("single_regrant");
        expect_out("single_regrant", 8'h00, 8'hFF, 8'h01);
        get_bus = '0;
        step("single_quiet");
    endtask

    task automatic test_all_rr();
        logic [N-1:0] prev;
        apply_reset();
        get_bus = 8'hFF; bus_enable = 2'b11;
        prev = '0;
        for (int i = 0; i < 4; i++) begin
            step("rr_pair");
            expect_out("rr_pair", 8'(2 * i), 8'(2 * i + 1), N'(3) << (2 * i));
            total++;
            if ((grant_vec & prev) !== '0) begin
                bad++;
                $display("FAIL rr_no_back_to_back got=%h want=00", grant_vec & prev);
            end
            prev = grant_vec;
        end
        expect_ptr("rr_ptr_after_four", 0);
    endtask

    task automatic test_wrap();
        apply_reset();
        get_bus = 8'hFF; bus_enable = 2'b11;
        for (int i = 0; i < 3; i++) step("wrap_setup");
        expect_ptr("wrap_ptr6", 6);
        get_bus = 8'b1100_0001;
        step("wrap_67");
        expect_out("wrap_67", 8'h06, 8'h07, 8'hC0);
        step("wrap_0");
        expect_out("wrap_0", 8'h00, 8'hFF, 8'h01);
        expect_ptr("wrap_ptr1", 1);
    endtask

    task automatic test_one_bus();
        apply_reset();
        get_bus = 8'h0C; bus_enable = 2'b10;
        step("onebus_2");
        expect_out("onebus_2", 8'hFF, 8'h02, 8'h04);
        step("onebus_3");
        expect_out("onebus_3", 8'hFF, 8'h03, 8'h08);
        bus_enable = 2'b00;
        step("nobus");
        expect_out("nobus", 8'hFF, 8'hFF, 8'h00);
        bus_enable = 2'b01;
        step("bus0_only");
        expect_out("bus0_only", 8'h02, 8'hFF, 8'h04);
    endtask

    task automatic test_flush();
        apply_reset();
        get_bus = 8'hFF; bus_enable = 2'b11;
        step("flush_pre");
        flush = 1'b1;
        step("flush_on");
        expect_out("flush_on", 8'hFF, 8'hFF, 8'h00);
        expect_ptr("flush_ptr_kept", 2);
        flush = 1'b0;
        step("flush_resume");
        expect_out("flush_resume", 8'h02, 8'h03, 8'h0C);
    endtask

    task automatic test_async_reset();
        apply_reset();
        get_bus = 8'hFF; bus_enable = 2'b11;
        step("areset_pre");
        step("areset_pre2");
        #2;
        reset = 1'b1;
        #1;
        expect_out("areset_immediate", 8'hFF, 8'hFF, 8'h00);
        expect_ptr("areset_ptr", 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_ptr = 0; m_gv = '0; q.delete();
        step("areset_after");
        expect_out("areset_after", 8'h00, 8'h01, 8'h03);
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 60; i++) begin
            get_bus    = N'($urandom);
            bus_enable = 2'($urandom);
            flush      = ($urandom_range(0, 9) == 0);
            step("random");
            total++;
            if (select_0 != 8'hFF && select_0 === select_1) begin
                bad++;
                $display("FAIL random_dup_bus got=%h want=distinct", select_0);
            end
        end
        flush = 1'b0;
    endtask

    initial begin
        total = 0; bad = 0;
        reset = 1'b1; get_bus = '0; bus_enable = 2'b00; flush = 1'b0;
        m_ptr = 0; m_gv = '0;
        test_reset();
        test_single();
        test_all_rr();
        test_wrap();
        test_one_bus();
        test_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Central scheduler for the two common data buses (cdb[0], cdb[1]) shared by all execution combos (ALU, branch, load/store, mult/div). Each cycle it picks up to two pending requesters in round-robin order and broadcasts their addresses on the per-bus select lines. Each combo's local `arbiter` compares those select lines against its `ARBITER_ADDRESS` to raise `bus_granted` and advance its reservation station.

## Interface
Parameters:
- `N`, 8: number of requesting combos, 2..32; requester i has address i.
- `IDLE_ADDRESS`, 8'hFF: select value meaning "bus unused"; must be ≥ N.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `get_bus`  in  N  bit i: requester i holds a completed result.
- `bus_enable`  in  2  bit k: cdb[k] may be granted this cycle.
- `flush`  in  1  synchronous; cancels pending grants (pipeline kill).
- `select_0`  out  8  address granted cdb[0], registered.
- `select_1`  out  8  address granted cdb[1], registered.
- `grant_vec`  out  N  one-hot-or-two-hot copy of current grants, registered.

## Operation
- Registers: `rr_ptr` (clog2(N) bits), `select_0`, `select_1`, `grant_vec`.
- Eligible set per cycle: `elig = get_bus & ~grant_vec`. A requester granted in cycle t is masked at the edge ending t, because its `get_bus` still reflects the result being broadcast.
- Scan order: rr_ptr, rr_ptr+1, …, N-1, 0, …, rr_ptr-1 (modulo N, wrap-around).
- Grant A: first eligible in scan order. Grant B: second eligible in scan order.
- Bus mapping:
  - Both buses enabled: A→cdb[0], B→cdb[1].
  - Only one bus enabled: A→that bus; the other bus is IDLE.
  - Neither enabled: both IDLE.
- Pointer update: rr_ptr ← (index of last granted requester + 1) mod N. Unchanged if nothing is granted.
- Requester with no grant keeps `get_bus` high and remains eligible. No request is dropped.
- `flush`: next-state selects are IDLE, `grant_vec` is 0, rr_ptr is unchanged. Flush has priority over all grants.
- A requester never appears on both buses in the same cycle.
- Upstream contract: `get_bus` must not rise for address ≥ N. Bits above N are not present.

## Timing
- Reset (async assert): select_0 = select_1 = IDLE_ADDRESS, grant_vec = 0, rr_ptr = 0. Deassert is synchronous to clk.
- Latency: `get_bus` high in cycle t → select visible in cycle t+1. The combo's `bus_granted` is combinational from select, and its result is driven on the bus in t+1.
- Each grant lasts exactly one cycle. A continuous requester is granted at most every other cycle (mask rule).
- Throughput: up to 2 results/cycle with ≥4 continuous requesters.
- Reset mid-operation: outputs go IDLE immediately. Any result in flight is lost, and the reservation stations are reset by the same signal.
- `bus_enable` is sampled in the same cycle as `get_bus`. Deasserting it does not affect a grant already registered.

## Structure
- Shared package `cdb_pkg`:
  - `cdb_addr_t` (logic [7:0])
  - `CDB_IDLE_ADDRESS` = 8'hFF
  - `CDB_BUS_COUNT` = 2
- Combo modules' `ARBITER_ADDRESS` values are defined in the same package as named constants, one per combo.
- Sub-module `rr_pick2`: combinational, inputs `elig[N]` and `ptr`; outputs first/second index plus valid bits. Implemented as a doubled-vector priority scan. `cdb_arbiter` holds only the registers, bus mapping, flush and pointer logic.

## Test plan
- Reset, then `get_bus`=8'b0000_0001, bus_enable=2'b11 → cycle+1: select_0=8'h00, select_1=8'hFF, grant_vec=8'h01. Next cycle (bit still high, masked): both selects 8'hFF.
- `get_bus`=8'hFF held 4 cycles, rr_ptr=0 → grant pairs (0,1), (2,3), (4,5), (6,7). Each granted index is masked in the cycle after its grant. No index is granted twice in consecutive cycles.
- rr_ptr=6 (after granting 5), `get_bus`=8'b1100_0001 → select_0=8'h06, select_1=8'h07. Next: select_0=8'h00, rr_ptr=1 (wrap-around).
- `get_bus`=8'h0C, bus_enable=2'b10 → select_0=8'hFF, select_1=8'h02. Next cycle select_1=8'h03.
- `flush`=1 with `get_bus`=8'hFF → both selects 8'hFF, grant_vec=0, rr_ptr unchanged. Grants resume the cycle after flush drops.
- Async `reset` pulse mid-cycle with grants active → selects become 8'hFF without waiting for a clock edge, and rr_ptr=0.
